// File: rtl/tcxo_dac_slew_spi_if.sv
// rtl/tcxo_dac_slew_spi_if.sv - loop-side and DAC-side signals of the TCXO DAC slew writer
interface tcxo_dac_slew_spi_if;
    logic [15:0] dat;
    logic        force_req;
    logic        sclk;
    logic        mosi;
    logic        sync_n;
    logic        busy;
    logic        done;
    logic [15:0] dac_cur;

    modport master (
        output dat, force_req,
        input  sclk, mosi, sync_n, busy, done, dac_cur
    );

    modport slave (
        input  dat, force_req,
        output sclk, mosi, sync_n, busy, done, dac_cur
    );
endinterface

// File: rtl/tcxo_dac_slew_spi.sv
// rtl/tcxo_dac_slew_spi.sv - slew-limited 24-bit SPI writer for an AD5662-class TCXO tuning DAC
module tcxo_dac_slew_spi #(
    parameter int          CLK_DIV  = 4,
    parameter logic [15:0] MAX_STEP = 16'd256,
    parameter int          GAP      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tcxo_dac_slew_spi_if.slave    bus
);

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_M1 = 16'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        sync_n_q, sync_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] dac_cur_q, dac_cur_d;
    logic [15:0] next_q, next_d;
    logic [23:0] shreg_q, shreg_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  bits_q, bits_d;
    logic        force_pend_q, force_pend_d;
    logic        first_pending_q, first_pending_d;

    logic [16:0] up_sum;
    logic [16:0] dn_diff;
    logic [15:0] dn_floor;
    logic [15:0] step_code;
    logic        start;

    assign up_sum   = {1'b0, dac_cur_q} + {1'b0, MAX_STEP};
    assign dn_diff  = {1'b0, dac_cur_q} - {1'b0, MAX_STEP};
    assign dn_floor = dn_diff[16] ? 16'h0000 : dn_diff[15:0];
    assign start    = first_pending_q || force_pend_q || bus.force_req || (bus.dat != dac_cur_q);

    // Slew-limited next code; the first frame after reset is unslewed since the DAC's power-on code is unknown
    always_comb begin
        step_code = dac_cur_q;
        if ((MAX_STEP == 16'd0) || first_pending_q) begin
            step_code = bus.dat;
        end else if (bus.dat > dac_cur_q) begin
            step_code = ({1'b0, bus.dat} < up_sum) ? bus.dat : up_sum[15:0];
        end else if (bus.dat < dac_cur_q) begin
            step_code = (bus.dat > dn_floor) ? bus.dat : dn_floor;
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below
    always_comb begin
        state_d         = state_q;
        sclk_d          = sclk_q;
        mosi_d          = mosi_q;
        sync_n_d        = sync_n_q;
        busy_d          = busy_q;
        done_d          = done_q;
        dac_cur_d       = dac_cur_q;
        next_d          = next_q;
        shreg_d         = shreg_q;
        cnt_d           = cnt_q;
        bits_d          = bits_q;
        first_pending_d = first_pending_q;
        force_pend_d    = force_pend_q | bus.force_req;

        case (state_q)
            ST_IDLE: begin
                force_pend_d = force_pend_q;
                if (start) begin
                    state_d      = ST_LOAD;
                    next_d       = step_code;
                    busy_d       = 1'b1;
                    force_pend_d = 1'b0;
                end
            end
            ST_LOAD: begin
                sync_n_d = 1'b0;
                mosi_d   = 1'b0;
                shreg_d  = {7'b0, next_q, 1'b0};
                cnt_d    = 16'd0;
                bits_d   = 5'd0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = 16'd0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bits_d = bits_q + 5'd1;
                    end else begin
                        sclk_d = 1'b1;
                        if (bits_q == 5'd24) begin
                            sync_n_d        = 1'b1;
                            mosi_d          = 1'b0;
                            dac_cur_d       = next_q;
                            first_pending_d = 1'b0;
                            state_d         = ST_GAP;
                        end else begin
                            mosi_d  = shreg_q[23];
                            shreg_d = {shreg_q[22:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (done_q) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == GAP_M1) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any partial frame at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            sclk_q          <= 1'b1;
            mosi_q          <= 1'b0;
            sync_n_q        <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            dac_cur_q       <= 16'h7FFF;
            next_q          <= 16'h7FFF;
            shreg_q         <= 24'h0;
            cnt_q           <= 16'd0;
            bits_q          <= 5'd0;
            force_pend_q    <= 1'b0;
            first_pending_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            sclk_q          <= sclk_d;
            mosi_q          <= mosi_d;
            sync_n_q        <= sync_n_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            dac_cur_q       <= dac_cur_d;
            next_q          <= next_d;
            shreg_q         <= shreg_d;
            cnt_q           <= cnt_d;
            bits_q          <= bits_d;
            force_pend_q    <= force_pend_d;
            first_pending_q <= first_pending_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.sync_n  = sync_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dac_cur = dac_cur_q;

endmodule

// File: tb/tb_tcxo_dac_slew_spi.sv
// tb/tb_tcxo_dac_slew_spi.sv - self-checking bench for tcxo_dac_slew_spi
module tb_tcxo_dac_slew_spi;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;

    tcxo_dac_slew_spi_if bus_a ();
    tcxo_dac_slew_spi_if bus_b ();

    tcxo_dac_slew_spi u_dut (
        .clk     (clk),
        .reset_n (rst_a),
        .bus     (bus_a)
    );

    tcxo_dac_slew_spi #(.CLK_DIV(2)) u_dut2 (
        .clk     (clk),
        .reset_n (rst_b),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor: reconstructs what the DAC would latch on each sclk fall
    logic [1:0]  sc, mo, sy, bu, dn;
    logic [1:0]  p_sc = 2'b11, p_mo = 2'b00, p_sy = 2'b11, p_bu = 2'b00;
    logic [23:0] sh [2];
    int          nbits [2];
    int          unstable [2];
    int          toggles [2];
    int          busy_rise [2];
    int          sync_fall [2];
    int          sync_rise [2];
    int          done_cyc [2];
    logic [23:0] fq0 [$];
    logic [23:0] fq1 [$];

    assign sc = {bus_b.sclk, bus_a.sclk};
    assign mo = {bus_b.mosi, bus_a.mosi};
    assign sy = {bus_b.sync_n, bus_a.sync_n};
    assign bu = {bus_b.busy, bus_a.busy};
    assign dn = {bus_b.done, bus_a.done};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sc[k] !== p_sc[k] || sy[k] !== p_sy[k]) toggles[k]++;
            if (!sy[k] && p_sy[k]) begin
                nbits[k] = 0;
                sync_fall[k] = cyc;
            end
            if (!sy[k] && p_sc[k] && !sc[k]) begin
                sh[k] = {sh[k][22:0], p_mo[k]};
                nbits[k]++;
                if (mo[k] !== p_mo[k]) unstable[k]++;
            end
            if (sy[k] && !p_sy[k]) begin
                sync_rise[k] = cyc;
                if (nbits[k] == 24) begin
                    if (k == 0) fq0.push_back(sh[k]);
                    else        fq1.push_back(sh[k]);
                end
            end
            if (bu[k] && !p_bu[k]) busy_rise[k] = cyc;
            if (dn[k]) done_cyc[k] = cyc;
        end
        p_sc = sc;
        p_mo = mo;
        p_sy = sy;
        p_bu = bu;
    end

    // Reference: a frame moves the code toward the target by at most ms, unslewed when first
    function automatic int slew_ref(int cur, int tgt, bit first, int ms);
        if (first || ms == 0) return tgt;
        if (tgt - cur > ms) return cur + ms;
        if (cur - tgt > ms) return cur - ms;
        return tgt;
    endfunction

    int model_cur = 16'h7FFF;
    bit model_first = 1'b1;

    task automatic wait_quiet(input int k, output bit ok);
        int q = 0;
        int n = 0;
        ok = 1'b1;
        while (q < 6) begin
            @(negedge clk);
            if (bu[k]) q = 0;
            else q++;
            n++;
            if (n > 20000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus_a.dat = 16'h7FFF;
        bus_a.force_req = 1'b0;
        bus_b.dat = 16'h1234;
        bus_b.force_req = 1'b0;
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        ncmp++; if (bus_a.sclk !== 1'b1) begin nfail++; $display("FAIL reset_sclk got %b want 1", bus_a.sclk); end
        ncmp++; if (bus_a.sync_n !== 1'b1) begin nfail++; $display("FAIL reset_sync_n got %b want 1", bus_a.sync_n); end
        ncmp++; if (bus_a.mosi !== 1'b0) begin nfail++; $display("FAIL reset_mosi got %b want 0", bus_a.mosi); end
        ncmp++; if (bus_a.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
        ncmp++; if (bus_a.done !== 1'b0) begin nfail++; $display("FAIL reset_done got %b want 0", bus_a.done); end
        ncmp++; if (bus_a.dac_cur !== 16'h7FFF) begin nfail++; $display("FAIL reset_dac_cur got %h want 7fff", bus_a.dac_cur); end
    endtask

    task automatic test_first_frame;
        bit ok;
        int t;
        fq0.delete();
        @(negedge clk);
        rst_a = 1'b1;
        wait_quiet(0, ok);
        ncmp++; if (!ok) begin nfail++; $display("FAIL first_timeout got busy want idle"); end
        ncmp++; if (fq0.size() != 1) begin nfail++; $display("FAIL first_count got %0d want 1", fq0.size()); end
        else begin
            ncmp++; if (fq0[0] !== 24'h007FFF) begin nfail++; $display("FAIL first_word got %h want 007fff", fq0[0]); end
        end
        ncmp++; if (sync_rise[0] - sync_fall[0] != 192) begin nfail++; $display("FAIL first_sync_low got %0d want 192", sync_rise[0] - sync_fall[0]); end
        ncmp++; if (done_cyc[0] - busy_rise[0] != 201) begin nfail++; $display("FAIL first_done_lat got %0d want 201", done_cyc[0] - busy_rise[0]); end
        model_cur = 16'h7FFF;
        model_first = 1'b0;
        t = toggles[0];
        repeat (300) @(negedge clk);
        ncmp++; if (toggles[0] != t) begin nfail++; $display("FAIL idle_toggles got %0d want %0d", toggles[0], t); end
        ncmp++; if (fq0.size() != 1) begin nfail++; $display("FAIL idle_frames got %0d want 1", fq0.size()); end
    endtask

    task automatic test_slew;
        bit ok;
        int c;
        int exp_q [$];
        c = model_cur;
        while (c != 16'h8400) begin
            c = slew_ref(c, 16'h8400, 1'b0, 256);
            exp_q.push_back(c);
        end
        fq0.delete();
        @(negedge clk);
        bus_a.dat = 16'h8400;
        wait_quiet(0, ok);
        ncmp++; if (!ok) begin nfail++; $display("FAIL slew_timeout got busy want idle"); end
        ncmp++; if (fq0.size() != exp_q.size()) begin nfail++; $display("FAIL slew_count got %0d want %0d", fq0.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < fq0.size(); i++) begin
            ncmp++; if (fq0[i] !== {8'h00, exp_q[i][15:0]}) begin nfail++; $display("FAIL slew_frame%0d got %h want %h", i, fq0[i], exp_q[i][15:0]); end
        end
        ncmp++; if (bus_a.dac_cur !== 16'h8400) begin nfail++; $display("FAIL slew_dac_cur got %h want 8400", bus_a.dac_cur); end
        model_cur = 16'h8400;
    endtask

    task automatic test_zero_sat;
        bit ok;
        rst_a = 1'b0;
        bus_a.dat = 16'h0080;
        fq0.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        wait_quiet(0, ok);
        ncmp++; if (fq0.size() != 1 || fq0[0] !== 24'(slew_ref(16'h8400, 16'h0080, 1'b1, 256))) begin
            nfail++; $display("FAIL unslewed_after_reset got n=%0d w=%h want 000080", fq0.size(), (fq0.size() > 0) ? fq0[0] : 24'hx);
        end
        fq0.delete();
        bus_a.dat = 16'h0000;
        wait_quiet(0, ok);
        ncmp++; if (fq0.size() != 1 || fq0[0] !== 24'(slew_ref(16'h0080, 0, 1'b0, 256))) begin
            nfail++; $display("FAIL zero_sat got n=%0d w=%h want 000000", fq0.size(), (fq0.size() > 0) ? fq0[0] : 24'hx);
        end
        ncmp++; if (bus_a.dac_cur !== 16'h0000) begin nfail++; $display("FAIL zero_dac_cur got %h want 0000", bus_a.dac_cur); end
        model_cur = 0;
    endtask

    task automatic test_force_busy;
        bit ok;
        int n;
        fq0.delete();
        @(negedge clk);
        bus_a.force_req = 1'b1;
        @(negedge clk);
        bus_a.force_req = 1'b0;
        n = 0;
        while (bus_a.sync_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ncmp++; if (bus_a.sync_n !== 1'b0) begin nfail++; $display("FAIL force_start got sync_n=%b want 0", bus_a.sync_n); end
        repeat (3) begin
            repeat (20) @(negedge clk);
            bus_a.force_req = 1'b1;
            @(negedge clk);
            bus_a.force_req = 1'b0;
        end
        wait_quiet(0, ok);
        ncmp++; if (fq0.size() != 2) begin nfail++; $display("FAIL force_count got %0d want 2", fq0.size()); end
        for (int i = 0; i < 2 && i < fq0.size(); i++) begin
            ncmp++; if (fq0[i] !== {8'h00, model_cur[15:0]}) begin nfail++; $display("FAIL force_frame%0d got %h want %h", i, fq0[i], model_cur[15:0]); end
        end
    endtask

    task automatic test_random;
        bit ok;
        int tgt, c;
        int exp_q [$];
        for (int it = 0; it < 6; it++) begin
            tgt = model_cur + int'($urandom_range(0, 2000)) - 1000;
            if (tgt < 0) tgt = 0;
            if (tgt > 65535) tgt = 65535;
            exp_q.delete();
            c = model_cur;
            while (c != tgt) begin
                c = slew_ref(c, tgt, 1'b0, 256);
                exp_q.push_back(c);
            end
            fq0.delete();
            @(negedge clk);
            bus_a.dat = tgt[15:0];
            wait_quiet(0, ok);
            ncmp++; if (fq0.size() != exp_q.size()) begin nfail++; $display("FAIL rand%0d_count got %0d want %0d", it, fq0.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < fq0.size(); i++) begin
                ncmp++; if (fq0[i] !== {8'h00, exp_q[i][15:0]}) begin nfail++; $display("FAIL rand%0d_frame%0d got %h want %h", it, i, fq0[i], exp_q[i][15:0]); end
            end
            ncmp++; if (bus_a.dac_cur !== tgt[15:0]) begin nfail++; $display("FAIL rand%0d_dac_cur got %h want %h", it, bus_a.dac_cur, tgt[15:0]); end
            model_cur = tgt;
        end
    endtask

    task automatic test_midframe_reset;
        bit ok;
        int n;
        logic [15:0] r;
        bus_a.dat = model_cur[15:0] ^ 16'h4000;
        n = 0;
        while (!(bus_a.sync_n === 1'b0 && nbits[0] >= 10) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ncmp++; if (nbits[0] < 10) begin nfail++; $display("FAIL mid_reach got bits=%0d want 10", nbits[0]); end
        #1 rst_a = 1'b0;
        #1;
        ncmp++; if (bus_a.sclk !== 1'b1 || bus_a.sync_n !== 1'b1 || bus_a.busy !== 1'b0) begin
            nfail++; $display("FAIL mid_async got sclk=%b sync_n=%b busy=%b want 1 1 0", bus_a.sclk, bus_a.sync_n, bus_a.busy);
        end
        ncmp++; if (bus_a.dac_cur !== 16'h7FFF) begin nfail++; $display("FAIL mid_dac_cur got %h want 7fff", bus_a.dac_cur); end
        r = 16'($urandom_range(0, 65535));
        bus_a.dat = r;
        fq0.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        wait_quiet(0, ok);
        ncmp++; if (fq0.size() != 1 || fq0[0] !== {8'h00, 16'(slew_ref(16'h7FFF, int'(r), 1'b1, 256))}) begin
            nfail++; $display("FAIL mid_unslewed got n=%0d w=%h want %h", fq0.size(), (fq0.size() > 0) ? fq0[0] : 24'hx, {8'h00, r});
        end
        model_cur = r;
    endtask

    task automatic test_bitlevel;
        bit ok;
        fq1.delete();
        @(negedge clk);
        rst_b = 1'b1;
        wait_quiet(1, ok);
        ncmp++; if (fq1.size() != 1) begin nfail++; $display("FAIL bit_count got %0d want 1", fq1.size()); end
        else begin
            ncmp++; if (fq1[0] !== 24'h001234) begin nfail++; $display("FAIL bit_word got %h want 001234", fq1[0]); end
        end
        ncmp++; if (unstable[1] != 0) begin nfail++; $display("FAIL bit_stable got %0d want 0", unstable[1]); end
        ncmp++; if (sync_rise[1] - sync_fall[1] != 96) begin nfail++; $display("FAIL bit_sync_low got %0d want 96", sync_rise[1] - sync_fall[1]); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_slew();
        test_zero_sat();
        test_force_busy();
        test_random();
        test_midframe_reset();
        test_bitlevel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/tcxo_dac_slew_spi.md
TCXO_DAC_SLEW_SPI -- requirements
Module: tcxo_dac_slew_spi

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 The block SHALL have parameter MAX_STEP, default 16'd256: largest code change per frame; 0 means unlimited.
REQ-003 The block SHALL have parameter GAP, default 8: minimum clk cycles SYNC_N stays high between frames, legal range 2 and up.
REQ-004 Port clk, input, 1 bit: single clock, the 200 MHz loop clock.
REQ-005 Port reset_n, input, 1 bit: reset is asynchronous and active-low.
REQ-006 Port dat, input, 16 bits: target DAC code from the PPS discipline loop, level-held.
REQ-007 Port force, input, 1 bit: single-cycle pulse that requests a frame even when the code is unchanged.
REQ-008 Port sclk, output, 1 bit: serial clock to the AD5662-class DAC; idles high.
REQ-009 Port mosi, output, 1 bit: serial data, MSB first.
REQ-010 Port sync_n, output, 1 bit: frame select, active low.
REQ-011 Port busy, output, 1 bit: frame in progress or in the inter-frame gap.
REQ-012 Port done, output, 1 bit: one-cycle pulse at the end of each frame's gap.
REQ-013 Port dac_cur, output, 16 bits: code most recently written to the DAC.

Function
REQ-014 The state machine SHALL have states IDLE, LOAD, SHIFT and GAP; all outputs SHALL be registered.
REQ-015 In IDLE, a frame SHALL start when any of the following is true: first_pending=1, force_pend=1, or dat!=dac_cur.
REQ-016 The target SHALL be sampled only in the IDLE cycle that starts a frame; changes to dat during LOAD, SHIFT or GAP SHALL be ignored until the next IDLE.
REQ-017 Slew limiting:
- next = dat if MAX_STEP=0 or first_pending=1;
- else if dat>dac_cur: next = min(dat, dac_cur+MAX_STEP), computed in 17 bits with no wrap;
- else if dat<dac_cur: next = max(dat, dac_cur-MAX_STEP), computed in 17 bits with floor 0;
- else next = dac_cur.
REQ-018 The frame SHALL be 24 bits: 6'b0, power-down bits 2'b00, then next[15:0].
REQ-019 LOAD SHALL last 1 cycle; at its end sync_n=0 and mosi=bit23, at cycle T.
REQ-020 SHIFT timing:
- sclk falls at T+CLK_DIV and every 2*CLK_DIV after that;
- sclk rises at T+2*CLK_DIV and every 2*CLK_DIV after that;
- mosi advances one bit on each sclk rise;
- the DAC samples mosi on sclk falling edges.
REQ-021 The 24th sclk fall SHALL occur at T+47*CLK_DIV; sclk SHALL rise and sync_n SHALL return to 1 at T+48*CLK_DIV, and SHIFT then ends.
REQ-022 dac_cur SHALL load next on the cycle sync_n rises, and first_pending SHALL clear on that same cycle.
REQ-023 GAP SHALL hold sync_n=1 and sclk=1 for GAP cycles, then pulse done for 1 cycle and return to IDLE.
REQ-024 busy SHALL be 1 from LOAD through the done cycle inclusive.
REQ-025 A force pulse arriving while busy=1 SHALL set force_pend, and the pending request SHALL be serviced at the next IDLE.
REQ-026 Multiple force pulses during one frame SHALL produce exactly one extra frame.
REQ-027 force_pend SHALL clear when LOAD is entered.
REQ-028 When dat==dac_cur and nothing is pending, the block SHALL stay in IDLE and sclk/sync_n SHALL not toggle.
REQ-029 A large step SHALL converge as successive frames back-to-back, each limited by MAX_STEP; the final frame SHALL land exactly on dat with no overshoot.

Reset
REQ-030 While reset_n=0 the block SHALL hold: state IDLE, sclk=1, sync_n=1, mosi=0, busy=0, done=0, dac_cur=16'h7FFF, force_pend=0, first_pending=1.
REQ-031 Reset asserted mid-frame SHALL return every output to its reset value immediately (asynchronously), abandon the partial frame and leave dac_cur=16'h7FFF.
REQ-032 On reset release, the first frame SHALL send dat unslewed, because the DAC's own power-on state is unknown.

Verification
REQ-033 Reset release with dat=16'h7FFF:
- the first frame is sent 24'h007FFF;
- sync_n is low for 48*4=192 cycles;
- done fires at 192+8+1 cycles after LOAD;
- no further frames follow.
REQ-034 Slew convergence: dac_cur=16'h7FFF, dat steps to 16'h8400, MAX_STEP=256 -> frames 16'h80FF, 16'h81FF, 16'h82FF, 16'h83FF, 16'h8400, then IDLE.
REQ-035 Saturation at zero: dac_cur=16'h0080, dat=16'h0000 -> single frame with code 16'h0000 (no wrap to 16'hFF80).
REQ-036 force while busy: three force pulses during one frame with dat unchanged -> exactly one repeat frame with the same code.
REQ-037 Mid-frame reset: reset_n=0 at bit 10 of SHIFT -> sclk=1, sync_n=1, busy=0 within the same cycle; the next frame after release is unslewed.
REQ-038 Bit-level check: CLK_DIV=2, frame 24'h001234 -> mosi is stable across every sclk fall and the 24 sampled bits equal 24'h001234.
